nios_system_sysid_checker: RTL and testbench

- Avalon-MM read master that reads the system-ID slave's control port after reset or on request.
- Compares the ID word (address 0) and timestamp word (address 1) against expected values.
- Reports pass/fail/timeout to the boot/status logic.
- Sits beside the Nios II on the same interconnect and gates the "system_ok" LED/status path.

---
 rtl/nios_system_sysid_checker.sv | 201 ++++++++++++++++++++
 tb/tb_nios_system_sysid_checker.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker: Avalon-MM read master that fetches the sysid slave's ID word
// (address 0) and timestamp word (address 1) after reset or on request. It compares both
// against the expected values and reports pass, fail or waitrequest timeout.
// Optional build macro SYSID_CHECK_RETRY_EN: failed passes are retried up to MAX_RETRIES
// times before done is pulsed, and the o_retry_count port is added.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480634848,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value
`ifdef SYSID_CHECK_RETRY_EN
    ,
    output logic [1:0]  o_retry_count
`endif
);

    localparam bit         LatZero   = (READ_LATENCY == 0);
    localparam logic [1:0] LatTarget = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        StIdle,
        StIdReq,
        StIdWait,
        StTsReq,
        StTsWait,
        StFinish
    } state_t;

    state_t      r_state;
    logic        r_auto_start;
    logic        r_avm_read;
    logic        r_avm_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic [15:0] r_to_cnt;
    logic [1:0]  r_lat_cnt;
`ifdef SYSID_CHECK_RETRY_EN
    logic [7:0]  r_retries;
`endif

    logic        w_accept;
    logic        w_stall;
    logic [16:0] w_to_next;
    logic        w_to_hit;
    logic        w_ts_capture;
    logic        w_match;
    logic        w_ok;
    logic        w_end;
    logic        w_retry;

    // Pass-termination decode: timestamp capture point, timeout hit and retry decision.
    always_comb begin
        w_accept     = r_avm_read & ~i_avm_waitrequest;
        w_stall      = r_avm_read & i_avm_waitrequest;
        w_to_next    = {1'b0, r_to_cnt} + 17'd1;
        w_to_hit     = w_stall && (w_to_next == 17'(TIMEOUT_CYCLES));
        w_ts_capture = (LatZero && (r_state == StTsReq) && w_accept) ||
                       (!LatZero && (r_state == StTsWait) && (r_lat_cnt == LatTarget));
        // The ID word is already registered by the time the timestamp arrives.
        w_match      = (r_id_value == EXPECTED_ID) && (i_avm_readdata == EXPECTED_TIMESTAMP);
        w_ok         = w_ts_capture && w_match;
        w_end        = w_ts_capture || w_to_hit;
`ifdef SYSID_CHECK_RETRY_EN
        w_retry      = w_end && !w_ok && (32'(r_retries) < MAX_RETRIES);
`else
        w_retry      = 1'b0;
`endif
    end

    // Check-pass FSM with registered bus and status outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_auto_start  <= 1'b1;
            r_avm_read    <= 1'b0;
            r_avm_address <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
            r_to_cnt      <= '0;
            r_lat_cnt     <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            r_retries     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start || r_auto_start) begin
                        r_auto_start  <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= 1'b0;
                        r_to_cnt      <= '0;
`ifdef SYSID_CHECK_RETRY_EN
                        r_retries     <= '0;
`endif
                        r_state       <= StIdReq;
                    end
                end
                StIdReq, StTsReq: begin
                    if (w_stall) begin
                        // Command held stable; only the stall counter moves.
                        r_to_cnt <= w_to_next[15:0];
                    end else begin
                        r_to_cnt <= '0;
                        if (LatZero) begin
                            if (r_state == StIdReq) begin
                                r_id_value    <= i_avm_readdata;
                                r_avm_address <= 1'b1;
                                r_state       <= StTsReq;
                            end else begin
                                r_ts_value <= i_avm_readdata;
                            end
                        end else begin
                            r_avm_read <= 1'b0;
                            r_lat_cnt  <= 2'd1;
                            r_state    <= (r_state == StIdReq) ? StIdWait : StTsWait;
                        end
                    end
                end
                StIdWait, StTsWait: begin
                    // r_lat_cnt holds the number of cycles elapsed since acceptance.
                    if (r_lat_cnt == LatTarget) begin
                        if (r_state == StIdWait) begin
                            r_id_value    <= i_avm_readdata;
                            r_avm_read    <= 1'b1;
                            r_avm_address <= 1'b1;
                            r_state       <= StTsReq;
                        end else begin
                            r_ts_value <= i_avm_readdata;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                StFinish: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            // End of pass overrides the per-state next values above.
            if (w_end) begin
                r_to_cnt <= '0;
                if (w_retry) begin
                    r_avm_read    <= 1'b1;
                    r_avm_address <= 1'b0;
                    r_state       <= StIdReq;
`ifdef SYSID_CHECK_RETRY_EN
                    r_retries     <= r_retries + 8'd1;
`endif
                end else begin
                    r_avm_read <= 1'b0;
                    r_done     <= 1'b1;
                    r_pass     <= w_ok;
                    r_timeout  <= w_to_hit;
                    r_state    <= StFinish;
                end
            end
        end
    end

    assign o_avm_address = r_avm_address;
    assign o_avm_read    = r_avm_read;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_timeout     = r_timeout;
    assign o_id_value    = r_id_value;
    assign o_ts_value    = r_ts_value;
`ifdef SYSID_CHECK_RETRY_EN
    assign o_retry_count = (r_retries > 8'd3) ? 2'd3 : r_retries[1:0];
`endif

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench for nios_system_sysid_checker. Instance 0 uses zero read latency and an
// 8-cycle timeout; instance 1 uses a 2-cycle read latency behind a pipelined slave model.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] GoodId  = 32'd0;
    localparam logic [31:0] GoodTs  = 32'd1480634848;  // 32'h5840B1E0
    localparam logic [31:0] GoodId1 = 32'h0000_0A5A;
`ifdef SYSID_CHECK_RETRY_EN
    localparam int ExpReadHigh = 32;  // 8 stalled cycles on each of 4 passes
`else
    localparam int ExpReadHigh = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0: zero-latency slave, data decoded straight from the address.
    logic        start0 = 1'b0, wr0 = 1'b0;
    logic        read0, addr0, busy0, done0, pass0, to0;
    logic [31:0] rd0, id0, ts0;
    logic [31:0] mem_id0 = GoodId, mem_ts0 = GoodTs;
    assign rd0 = addr0 ? mem_ts0 : mem_id0;

    // Instance 1: data valid only exactly 2 cycles after acceptance, junk otherwise.
    logic        start1 = 1'b0, wr1 = 1'b0;
    logic        read1, addr1, busy1, done1, pass1, to1;
    logic [31:0] rd1, id1, ts1;
    logic [31:0] mem_id1 = GoodId1, mem_ts1 = GoodTs;
    logic        p1_v, p1_a, p2_v, p2_a;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v <= 1'b0; p1_a <= 1'b0; p2_v <= 1'b0; p2_a <= 1'b0;
        end else begin
            p1_v <= read1 & ~wr1;
            p1_a <= addr1;
            p2_v <= p1_v;
            p2_a <= p1_a;
        end
    end
    assign rd1 = p2_v ? (p2_a ? mem_ts1 : mem_id1) : 32'hBAD0_BAD0;

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0] rc0, rc1;
`endif

    nios_system_sysid_checker #(
        .READ_LATENCY  (0),
        .TIMEOUT_CYCLES(8)
    ) u_dut0 (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_start          (start0),
        .o_avm_address    (addr0),
        .o_avm_read       (read0),
        .i_avm_waitrequest(wr0),
        .i_avm_readdata   (rd0),
        .o_busy           (busy0),
        .o_done           (done0),
        .o_pass           (pass0),
        .o_timeout        (to0),
        .o_id_value       (id0),
        .o_ts_value       (ts0)
`ifdef SYSID_CHECK_RETRY_EN
        ,
        .o_retry_count    (rc0)
`endif
    );

    nios_system_sysid_checker #(
        .EXPECTED_ID   (GoodId1),
        .READ_LATENCY  (2),
        .TIMEOUT_CYCLES(255)
    ) u_dut1 (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_start          (start1),
        .o_avm_address    (addr1),
        .o_avm_read       (read1),
        .i_avm_waitrequest(wr1),
        .i_avm_readdata   (rd1),
        .o_busy           (busy1),
        .o_done           (done1),
        .o_pass           (pass1),
        .o_timeout        (to1),
        .o_id_value       (id1),
        .o_ts_value       (ts1)
`ifdef SYSID_CHECK_RETRY_EN
        ,
        .o_retry_count    (rc1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
    endtask

    // Cycles until done0 is seen (0 if already high), -1 if the budget expires.
    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        if (done0 !== 1'b1) cyc = -1;
    endtask

    task automatic wait_done1(output int cyc);
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        if (done1 !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        int cyc;
        step();
        rst = 1'b1;
        repeat (2) step();
        n_tests++;
        if ({read0, addr0, busy0, done0, pass0, to0} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {read0, addr0, busy0, done0, pass0, to0});
        end
        n_tests++;
        if (id0 !== 32'd0 || ts0 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got id %h ts %h expected 0/0", id0, ts0);
        end
        rst = 1'b0;
        wait_done0(cyc);
        n_tests++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL auto_latency: got %0d cycles expected 3", cyc);
        end
        n_tests++;
        if (pass0 !== 1'b1 || to0 !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_status: got pass %b timeout %b expected 1/0", pass0, to0);
        end
        n_tests++;
        if (id0 !== GoodId || ts0 !== GoodTs) begin
            n_fail++;
            $display("FAIL auto_data: got id %h ts %h expected %h/%h", id0, ts0, GoodId, GoodTs);
        end
        step();
        n_tests++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got done %b busy %b expected 0/0", done0, busy0);
        end
        // Reset in the middle of a pass must abort asynchronously and re-arm auto start.
        pulse_start0();
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy0 !== 1'b0 || read0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort: got busy %b read %b expected 0/0", busy0, read0);
        end
        step();
        rst = 1'b0;
        wait_done0(cyc);
        n_tests++;
        if (cyc !== 3 || pass0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_auto: got %0d cycles pass %b expected 3/1", cyc, pass0);
        end
    endtask

    task automatic test_mismatch();
        int cyc;
        step();
        mem_ts0 = 32'hDEAD_BEEF;
        pulse_start0();
        wait_done0(cyc);
        n_tests++;
        if (cyc < 0) begin
            n_fail++;
            $display("FAIL mismatch_done: got no done expected done");
        end
        n_tests++;
        if (pass0 !== 1'b0 || to0 !== 1'b0 || ts0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mismatch: got pass %b timeout %b ts %h expected 0/0/deadbeef",
                     pass0, to0, ts0);
        end
        mem_ts0 = GoodTs;
        step();
    endtask

    task automatic test_timeout();
        int hi;
        int dn;
        int rd;
        wr0 = 1'b1;
        pulse_start0();
        hi = 0;
        while (read0 === 1'b1 && hi < 100) begin
            hi++;
            step();
        end
        n_tests++;
        if (hi !== ExpReadHigh) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d read cycles expected %0d", hi, ExpReadHigh);
        end
        n_tests++;
        if (done0 !== 1'b1 || to0 !== 1'b1 || pass0 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_status: got done %b timeout %b pass %b expected 1/1/0",
                     done0, to0, pass0);
        end
        n_tests++;
        if (id0 !== GoodId || ts0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL timeout_keep: got id %h ts %h expected %h/deadbeef", id0, ts0, GoodId);
        end
        dn = 0;
        rd = 0;
        repeat (20) begin
            step();
            if (done0 === 1'b1) dn++;
            if (read0 === 1'b1) rd++;
        end
        n_tests++;
        if (dn !== 0 || rd !== 0 || to0 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_after: got done %0d read %0d timeout %b expected 0/0/1",
                     dn, rd, to0);
        end
        wr0 = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int dn;
        pulse_start0();
        n_tests++;
        if (busy0 !== 1'b1 || to0 !== 1'b0 || pass0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clear: got busy %b timeout %b pass %b expected 1/0/0",
                     busy0, to0, pass0);
        end
        pulse_start0();  // while busy: ignored
        wait_done0(cyc);
        n_tests++;
        if (cyc < 0 || pass0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got cycles %0d pass %b expected done and 1", cyc, pass0);
        end
        pulse_start0();  // coincides with done: ignored
        n_tests++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_on_done: got busy %b expected 0", busy0);
        end
        pulse_start0();  // first idle cycle after done: honoured
        n_tests++;
        if (busy0 !== 1'b1 || pass0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_after_done: got busy %b pass %b expected 1/0", busy0, pass0);
        end
        dn = 0;
        repeat (15) begin
            if (done0 === 1'b1) dn++;
            step();
        end
        n_tests++;
        if (dn !== 1 || pass0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d done pulses pass %b expected 1/1", dn, pass0);
        end
    endtask

    task automatic test_latency_stall();
        int cyc;
        cyc = 0;
        while (busy1 !== 1'b0 && cyc < 50) begin
            step();
            cyc++;
        end
        wr1 = 1'b1;
        pulse_start1();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (read1 !== 1'b1 || addr1 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got read %b addr %b expected 1/0", i, read1, addr1);
            end
            step();
        end
        wr1 = 1'b0;
        step();
        n_tests++;
        if (read1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_read_drop: got read %b expected 0", read1);
        end
        step();
        step();
        n_tests++;
        if (read1 !== 1'b1 || addr1 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_capture_time: got read %b addr %b expected 1/1", read1, addr1);
        end
        wait_done1(cyc);
        n_tests++;
        if (cyc < 0 || pass1 !== 1'b1 || to1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_status: got cycles %0d pass %b timeout %b expected done 1/0",
                     cyc, pass1, to1);
        end
        n_tests++;
        if (id1 !== GoodId1 || ts1 !== GoodTs) begin
            n_fail++;
            $display("FAIL lat_data: got id %h ts %h expected %h/%h", id1, ts1, GoodId1, GoodTs);
        end
    endtask

`ifdef SYSID_CHECK_RETRY_EN
    task automatic test_retry();
        int dn;
        step();
        mem_id0 = 32'h0BAD_0001;
        pulse_start0();
        step();  // bad ID captured at this edge
        mem_id0 = GoodId;
        dn = 0;
        repeat (20) begin
            if (done0 === 1'b1) dn++;
            step();
        end
        n_tests++;
        if (dn !== 1 || pass0 !== 1'b1) begin
            n_fail++;
            $display("FAIL retry_done: got %0d done pulses pass %b expected 1/1", dn, pass0);
        end
        n_tests++;
        if (rc0 !== 2'd1) begin
            n_fail++;
            $display("FAIL retry_count: got %0d expected 1", rc0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mismatch();
        test_timeout();
        test_back_to_back();
        test_latency_stall();
`ifdef SYSID_CHECK_RETRY_EN
        test_retry();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
